// File: rtl/hit_window_pkg.sv
// Shared types and constants for the windowed hit accumulator.
package hit_window_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACC  = 1'b1
   } win_state_t;

   localparam int               DROP_W   = 8;
   localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

endpackage

// File: rtl/hit_window_slot.sv
// Single-entry valid/ready output register with a saturating counter of
// results that arrived while the slot was still occupied.
module hit_window_slot
   import hit_window_pkg::*;
#(
   parameter int CNT_W = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [CNT_W-1:0]  i_res_cnt,
   input  logic              i_res_over,
   input  logic              i_res_stb,
   input  logic              i_rdy,
   output logic [CNT_W-1:0]  o_cnt,
   output logic              o_over,
   output logic              o_vld,
   output logic [DROP_W-1:0] o_drop_cnt
);

   logic [CNT_W-1:0]  r_cnt;
   logic              r_over;
   logic              r_vld;
   logic [DROP_W-1:0] r_drop_cnt;
   logic              w_free;

   // A held result leaving this edge frees the slot for a new one.
   assign w_free = ~r_vld | i_rdy;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_over     <= 1'b0;
         r_vld      <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (i_res_stb && w_free) begin
            r_cnt  <= i_res_cnt;
            r_over <= i_res_over;
            r_vld  <= 1'b1;
         end else if (r_vld && i_rdy) begin
            r_vld <= 1'b0;
         end

         if (i_res_stb && !w_free && (r_drop_cnt != DROP_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   assign o_cnt      = r_cnt;
   assign o_over     = r_over;
   assign o_vld      = r_vld;
   assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/hit_window_acc.sv
// Counts set reduction results over windows of WINDOW_LEN valid samples and
// presents each window's count and threshold flag through a one-entry slot.
module hit_window_acc
   import hit_window_pkg::*;
#(
   parameter int WINDOW_LEN = 16,
   parameter int THRESH     = 8,
   localparam int CNT_W     = $clog2(WINDOW_LEN + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_hit,
   input  logic              i_hit_vld,
   input  logic              i_clr,
   output logic [CNT_W-1:0]  o_cnt,
   output logic              o_over,
   output logic              o_vld,
   input  logic              i_rdy,
   output logic              o_busy,
   output logic [DROP_W-1:0] o_drop_cnt
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW_LEN - 1);
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

   win_state_t       r_state;
   win_state_t       w_state_next;
   logic [CNT_W-1:0] r_smp_cnt;
   logic [CNT_W-1:0] r_hit_cnt;
   logic             w_last;
   logic             w_res_stb;
   logic [CNT_W-1:0] w_result;
   logic             w_over;

   assign w_last    = i_hit_vld && (r_smp_cnt == LAST_IDX);
   // A clear on the closing sample discards the window entirely.
   assign w_res_stb = w_last && !i_clr;
   assign w_result  = r_hit_cnt + {{(CNT_W-1){1'b0}}, i_hit};
   assign w_over    = (w_result >= THRESH_C);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (!i_clr && i_hit_vld) begin
               w_state_next = S_ACC;
            end
         end
         S_ACC: begin
            if (i_clr || w_last) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_smp_cnt <= '0;
         r_hit_cnt <= '0;
      end else if (i_clr || w_last) begin
         r_smp_cnt <= '0;
         r_hit_cnt <= '0;
      end else if (i_hit_vld) begin
         r_smp_cnt <= r_smp_cnt + 1'b1;
         r_hit_cnt <= w_result;
      end
   end

   assign o_busy = (r_state == S_ACC);

   hit_window_slot #(
      .CNT_W (CNT_W)
   ) u_slot (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_res_cnt  (w_result),
      .i_res_over (w_over),
      .i_res_stb  (w_res_stb),
      .i_rdy      (i_rdy),
      .o_cnt      (o_cnt),
      .o_over     (o_over),
      .o_vld      (o_vld),
      .o_drop_cnt (o_drop_cnt)
   );

endmodule

// File: tb/tb_hit_window_acc.sv
// Scoreboard bench for hit_window_acc with WINDOW_LEN=4, THRESH=3.
module tb_hit_window_acc;

   localparam int WL    = 4;
   localparam int TH    = 3;
   localparam int CNT_W = $clog2(WL + 1);

   logic             i_clk;
   logic             i_rst;
   logic             i_hit;
   logic             i_hit_vld;
   logic             i_clr;
   logic [CNT_W-1:0] o_cnt;
   logic             o_over;
   logic             o_vld;
   logic             i_rdy;
   logic             o_busy;
   logic [7:0]       o_drop_cnt;

   int checks = 0;
   int errors = 0;
   logic [CNT_W:0] exp_q[$];

   hit_window_acc #(
      .WINDOW_LEN (WL),
      .THRESH     (TH)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_hit      (i_hit),
      .i_hit_vld  (i_hit_vld),
      .i_clr      (i_clr),
      .o_cnt      (o_cnt),
      .o_over     (o_over),
      .o_vld      (o_vld),
      .i_rdy      (i_rdy),
      .o_busy     (o_busy),
      .o_drop_cnt (o_drop_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic expect_res(input int cnt, input logic over);
      exp_q.push_back({CNT_W'(cnt), over});
   endtask

   // One clock of stimulus; inputs change 1 time unit after the rising edge.
   task automatic step(input logic h, input logic v, input logic c);
      i_hit     = h;
      i_hit_vld = v;
      i_clr     = c;
      @(posedge i_clk);
      #1;
      i_hit     = 1'b0;
      i_hit_vld = 1'b0;
      i_clr     = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: a transfer happens at the next edge whenever o_vld && i_rdy.
   logic             hold_prev = 1'b0;
   logic [CNT_W-1:0] cnt_prev;
   logic             over_prev;

   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (hold_prev) begin
            chk("hold_vld", int'(o_vld), 1);
            chk("hold_cnt", int'(o_cnt), int'(cnt_prev));
            chk("hold_over", int'(o_over), int'(over_prev));
         end
         if (o_vld && i_rdy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", int'(o_cnt), -1);
            end else begin
               logic [CNT_W:0] e;
               e = exp_q.pop_front();
               chk("xfer_cnt", int'(o_cnt), int'(e[CNT_W:1]));
               chk("xfer_over", int'(o_over), int'(e[0]));
            end
         end
         hold_prev = o_vld && !i_rdy;
         cnt_prev  = o_cnt;
         over_prev = o_over;
      end else begin
         hold_prev = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b1; i_hit = 1'b0; i_hit_vld = 1'b0; i_clr = 1'b0; i_rdy = 1'b1;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;
      chk("rst_cnt", int'(o_cnt), 0);
      chk("rst_over", int'(o_over), 0);
      chk("rst_vld", int'(o_vld), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_drop", int'(o_drop_cnt), 0);

      // Reset mid-window, then a fresh window 0,0,1,0 -> 1
      step(1, 1, 0); step(1, 1, 0);
      chk("mid_busy", int'(o_busy), 1);
      i_rst = 1'b1;
      #2;
      chk("async_rst_busy", int'(o_busy), 0);
      @(posedge i_clk); #1 i_rst = 1'b0;
      expect_res(1, 1'b0);
      step(0, 1, 0); step(0, 1, 0); step(1, 1, 0);
      chk("fresh_vld_early", int'(o_vld), 0);
      step(0, 1, 0);
      chk("fresh_vld", int'(o_vld), 1);
      idle(2);

      // Back-to-back windows 1,1,0,1 | 0,0,1,0
      expect_res(3, 1'b1);
      expect_res(1, 1'b0);
      step(1, 1, 0); step(1, 1, 0); step(0, 1, 0); step(1, 1, 0);
      chk("b2b_vld1", int'(o_vld), 1);
      chk("b2b_cnt1", int'(o_cnt), 3);
      step(0, 1, 0); step(0, 1, 0); step(1, 1, 0); step(0, 1, 0);
      chk("b2b_vld2", int'(o_vld), 1);
      chk("b2b_cnt2", int'(o_cnt), 1);
      idle(2);
      chk("b2b_drop", int'(o_drop_cnt), 0);

      // Gaps: invalid cycles carry i_hit=1 and must be ignored
      expect_res(4, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step(1, 1, 0);
         step(1, 0, 0);
      end
      idle(2);

      // Backpressure: three windows held off, first is kept
      i_rdy = 1'b0;
      expect_res(3, 1'b1);
      step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(0, 1, 0);
      for (int k = 0; k < 4; k++) step(0, 1, 0);
      step(1, 1, 0); step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
      chk("bp_drop", int'(o_drop_cnt), 2);
      chk("bp_cnt", int'(o_cnt), 3);
      // Ready rises exactly with the closing sample: swap, no drop
      expect_res(2, 1'b0);
      step(1, 1, 0); step(1, 1, 0); step(0, 1, 0);
      i_rdy = 1'b1;
      step(0, 1, 0);
      chk("swap_vld", int'(o_vld), 1);
      chk("swap_cnt", int'(o_cnt), 2);
      chk("swap_drop", int'(o_drop_cnt), 2);
      idle(2);

      // Clear together with the closing sample
      step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(1, 1, 1);
      idle(2);
      chk("clr_last_vld", int'(o_vld), 0);
      chk("clr_last_drop", int'(o_drop_cnt), 2);
      chk("clr_last_busy", int'(o_busy), 0);
      // Clear after two samples: the next window needs four fresh samples
      step(0, 1, 0); step(0, 1, 0); step(0, 0, 1);
      chk("clr_busy", int'(o_busy), 0);
      expect_res(4, 1'b1);
      step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
      chk("clr_fresh_early", int'(o_vld), 0);
      step(1, 1, 0);
      chk("clr_fresh_vld", int'(o_vld), 1);
      idle(2);

      // Saturation of the drop counter
      i_rdy = 1'b0;
      expect_res(0, 1'b0);
      for (int w = 0; w < 300; w++) begin
         for (int k = 0; k < 4; k++) step(0, 1, 0);
      end
      chk("sat_drop", int'(o_drop_cnt), 255);
      i_rdy = 1'b1;
      idle(3);
      chk("sat_drop_after", int'(o_drop_cnt), 255);
      chk("sat_vld_after", int'(o_vld), 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
